hyperram_responder: RTL and testbench
=====================================

// Module: hyperram_responder
// PURPOSE
//  Synthesizable HyperBus device (HyperRAM responder): the target end of the bus driven by wb_hyperram.
//  Decodes the 6-byte CA phase, counts initial latency and serves DDR read/write bursts from on-chip 16-bit RAM.
//  Sits on the pad side of wb_hyperram (internal loopback on iCE40 / sim); clocked by the same system clock.
//  Detects hb_clk toggles by oversampling, one byte per toggle.
// PARAMETERS
//  ADDR_W        10       word-address width; RAM depth 2**ADDR_W x 16 bit
//  LATENCY_CLKS  6        initial latency in hb_clk periods (used when CR0 not compiled)
//  FIXED_LAT     1        1: always 2x latency (RWDS high in CA); 0: 1x latency
// PORTS
//  wb_clk_i     in   1   system clock; hb_clk_i toggles at most once per wb_clk_i
//  wb_rst_i     in   1   asynchronous reset, active high
//  hb_rstn_i    in   1   HyperBus reset, active low; synchronous effect equivalent to wb_rst_i except RAM contents
//  hb_csn_i     in   1   chip select, active low
//  hb_clk_i     in   1   HyperBus clock; each level change = one DDR edge
//  hb_dq_i      in   8   DQ from controller
//  hb_dq_o      out  8   DQ to controller
//  hb_dq_oen    out  1   DQ output enable, active low
//  hb_rwds_i    in   1   RWDS from controller (write byte mask, 1 = masked)
//  hb_rwds_o    out  1   RWDS to controller (latency flag in CA, read strobe)
//  hb_rwds_oen  out  1   RWDS output enable, active low
//  busy_o       out  1   1 while state != IDLE
// BEHAVIOUR
//  Reset: hb_dq_o=0, hb_dq_oen=1, hb_rwds_o=0, hb_rwds_oen=1, busy_o=0, state IDLE; RAM not cleared.
//  edge = hb_clk_i ^ hb_clk_q (registered prior value); all capture on wb_clk_i when edge && !hb_csn_i.
//  hb_csn_i high in any state -> IDLE next cycle, both OENs -> 1, no further RAM writes; byte already written stays.
//  IDLE: csn falls -> CA; ca_cnt=0; drive hb_rwds_oen=0, hb_rwds_o=double_lat.
//  CA: shift in 6 bytes MSB first into ca[47:0]. ca[47]=read, ca[46]=register space, ca[45]=linear burst.
//   word addr = {ca[44:16], ca[2:0]} truncated to ADDR_W. After 6th edge:
//   reg-space write -> REG_WR (zero latency); else -> LAT, lat_cnt = 2*L*(double_lat?2:1) edges.
//  LAT: decrement per edge; RWDS released (oen=1) after CA for writes. At lat_cnt==1 edge -> WRITE or READ;
//   for READ, byte 0 ([15:8]) and hb_dq_oen=0, hb_rwds_o=0 registered on that same edge.
//  WRITE: even edge -> byte [15:8], odd edge -> [7:0]; byte written iff hb_rwds_i==0 at that edge.
//  READ: each edge advances one byte and toggles hb_rwds_o; outputs valid 1 wb_clk after edge.
//  Address increments after odd byte. Linear: wraps mod 2**ADDR_W. Wrapped (ca[45]=0): wraps within aligned 16-word group.
//  REG_WR: 2 bytes into CR0 (see CONFIGURATION), then hold in REG_WR ignoring edges until csn high.
//  Reg-space read: returns CR0 after latency (same path as READ, addr ignored).
//  Latency L: CR0[7:4] decode (0000=5,0001=6,1110=3,1111=4, others=6) if compiled, else LATENCY_CLKS.
//  double_lat: CR0[3] if compiled, else FIXED_LAT.
//  wb_rst_i mid-burst: immediate return to reset values; burst abandoned.
// CONFIGURATION
//  `HYPERRAM_RESPONDER_CR0_EN defined: 16-bit CR0 register, reset 16'h8F1F.
//   Reg write CA with ca[0]=0 ({ca[24:16],ca[2:0]}==0x800 selects CR0) updates it; latency/fixed taken from it.
//  Undefined: no CR0; reg-space writes consumed and dropped; reg-space reads return 16'h0000.
//   Latency from parameters only.
// STRUCTURE
//  hyperram_pkg: CA bit index localparams, state_t enum (IDLE,CA,LAT,WRITE,READ,REG_WR), CR0_RESET, latency decode function.
//  Sub-module hyperram_resp_mem: 2**ADDR_W x 16 RAM, 2-bit byte-enable write, sync read.
//   The next word is fetched during the odd byte so the even edge never stalls.
// TESTING
//  1 Reset mid-READ: assert wb_rst_i -> all OENs 1, busy_o 0 same cycle; next transaction works.
//  2 Write 0x1234,0x5678 at word 0x010, linear, L=6 fixed -> RAM[0x10]=0x1234, RAM[0x11]=0x5678;
//    read back -> bytes 12,34,56,78, RWDS toggling 0,1,0,1.
//  3 Write with RWDS=1 on second byte over 0xFFFF -> RAM=0x12FF; csn high after 1 byte -> only [15:8] changed.
//  4 Wrapped read 4 words from word 0x00E -> 0x00E,0x00F,0x000,0x001.
//    Linear from 2**ADDR_W-1 -> wraps to 0.
//  5 CR0_EN: reg write 0x8FE7 (L=3, 1x) -> RWDS low in CA; read data after 6 edges;
//    without macro: write ignored, 2x L=6 kept.
//  6 Back-to-back: csn high 1 cycle between write and read -> second CA decoded correctly.

Source files
------------

// File: rtl/hyperram_pkg.sv
// Shared definitions for the HyperRAM responder: CA bit positions, FSM states,
// CR0 reset value and the latency helpers.
// Ports: none (package).
package hyperram_pkg;

  localparam int unsigned CA_RD  = 47;   // 1 = read transaction
  localparam int unsigned CA_REG = 46;   // 1 = register space
  localparam int unsigned CA_LIN = 45;   // 1 = linear burst, 0 = wrapped
  localparam int unsigned LAT_W  = 8;    // latency edge counter width

  localparam logic [15:0] CR0_RESET = 16'h8F1F;
  localparam logic [11:0] CR0_SEL   = 12'h800;

  typedef enum logic [2:0] {
    IDLE,
    CA,
    LAT,
    WRITE,
    READ,
    REG_WR
  } state_t;

  // CR0[7:4] initial latency code to latency in hb_clk periods
  function automatic logic [3:0] cr0_latency(input logic [3:0] code);
    case (code)
      4'b0000: cr0_latency = 4'd5;
      4'b0001: cr0_latency = 4'd6;
      4'b1110: cr0_latency = 4'd3;
      4'b1111: cr0_latency = 4'd4;
      default: cr0_latency = 4'd6;
    endcase
  endfunction

  // Latency in DDR edges: two edges per hb_clk period, doubled for 2x latency
  function automatic logic [LAT_W-1:0] lat_edges(input logic [3:0] l, input logic dbl);
    lat_edges = dbl ? LAT_W'({l, 2'b00}) : LAT_W'({l, 1'b0});
  endfunction

endpackage

// File: rtl/hyperram_responder_if.sv
// HyperBus pad-side signal bundle between the controller (master) and the
// HyperRAM responder (slave).
// Signals: hb_rstn_i, hb_csn_i, hb_clk_i, hb_dq_i, hb_rwds_i (controller -> device);
//          hb_dq_o, hb_dq_oen, hb_rwds_o, hb_rwds_oen (device -> controller).
interface hyperram_responder_if;
  logic       hb_rstn_i;
  logic       hb_csn_i;
  logic       hb_clk_i;
  logic [7:0] hb_dq_i;
  logic [7:0] hb_dq_o;
  logic       hb_dq_oen;
  logic       hb_rwds_i;
  logic       hb_rwds_o;
  logic       hb_rwds_oen;

  modport master (
    output hb_rstn_i, hb_csn_i, hb_clk_i, hb_dq_i, hb_rwds_i,
    input  hb_dq_o, hb_dq_oen, hb_rwds_o, hb_rwds_oen
  );

  modport slave (
    input  hb_rstn_i, hb_csn_i, hb_clk_i, hb_dq_i, hb_rwds_i,
    output hb_dq_o, hb_dq_oen, hb_rwds_o, hb_rwds_oen
  );
endinterface

// File: rtl/hyperram_resp_mem.sv
// 2**ADDR_W x 16 responder RAM with per-byte write enables and registered read.
// Ports: clk; we/be/waddr/wdata write port; raddr/rdata synchronous read port.
module hyperram_resp_mem #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [1:0]        be,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [15:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [15:0]       rdata
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [15:0] mem [DEPTH];

  // Contents are never reset
  always_ff @(posedge clk) begin
    if (we && be[1]) mem[waddr][15:8] <= wdata[15:8];
    if (we && be[0]) mem[waddr][7:0]  <= wdata[7:0];
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/hyperram_responder.sv
// HyperBus device (HyperRAM responder): decodes the 6-byte CA phase, counts the
// initial latency and serves DDR read/write bursts from on-chip RAM. hb_clk_i
// level changes are detected by oversampling on wb_clk_i, one byte per change.
// Optional CR0 register: define HYPERRAM_RESPONDER_CR0_EN.
// Ports: wb_clk_i, wb_rst_i (async, active high); hb (HyperBus slave modport);
//        busy_o (high while not IDLE).
module hyperram_responder
  import hyperram_pkg::*;
#(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned LATENCY_CLKS = 6,
  parameter int unsigned FIXED_LAT    = 1
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  hyperram_responder_if.slave   hb,
  output logic                  busy_o
);

  state_t            state_q, state_d;
  logic              hb_clk_q;
  logic [39:0]       ca_q, ca_d;
  logic [2:0]        ca_cnt_q, ca_cnt_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              is_rd_q, is_rd_d, is_reg_q, is_reg_d, lin_q, lin_d;
  logic              odd_q, odd_d;
  logic [7:0]        lo_q, lo_d;
  logic [7:0]        dq_q, dq_d;
  logic              dq_oen_q, dq_oen_d, rwds_q, rwds_d, rwds_oen_q, rwds_oen_d;
  logic              busy_q;

  logic              edge_c, cap_c, we_c, dbl_c;
  logic [1:0]        be_c;
  logic [3:0]        lat_l_c;
  logic [47:0]       ca_full_c;
  logic [ADDR_W-1:0] addr_inc_c, raddr_c;
  logic [15:0]       mem_rdata, word_c, reg_word_c;

`ifdef HYPERRAM_RESPONDER_CR0_EN
  logic [15:0] cr0_q, cr0_d;
  logic [7:0]  reg_hi_q, reg_hi_d;
  logic        cr0_sel_q, cr0_sel_d;
  assign lat_l_c    = cr0_latency(cr0_q[7:4]);
  assign dbl_c      = cr0_q[3];
  assign reg_word_c = cr0_q;
`else
  assign lat_l_c    = 4'(LATENCY_CLKS);
  assign dbl_c      = 1'(FIXED_LAT);
  assign reg_word_c = 16'h0000;
`endif

  assign edge_c     = hb.hb_clk_i ^ hb_clk_q;
  assign cap_c      = edge_c && !hb.hb_csn_i;
  assign ca_full_c  = {ca_q, hb.hb_dq_i};
  // Wrapped bursts stay inside the aligned 16-word group
  assign addr_inc_c = lin_q ? addr_q + ADDR_W'(1) : {addr_q[ADDR_W-1:4], addr_q[3:0] + 4'd1};
  // Prefetch the next word while the odd byte is on the bus
  assign raddr_c    = odd_q ? addr_inc_c : addr_q;
  assign word_c     = is_reg_q ? reg_word_c : mem_rdata;

  hyperram_resp_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk   (wb_clk_i),
    .we    (we_c),
    .be    (be_c),
    .waddr (addr_q),
    .wdata ({hb.hb_dq_i, hb.hb_dq_i}),
    .raddr (raddr_c),
    .rdata (mem_rdata)
  );

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    ca_d       = ca_q;
    ca_cnt_d   = ca_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    addr_d     = addr_q;
    is_rd_d    = is_rd_q;
    is_reg_d   = is_reg_q;
    lin_d      = lin_q;
    odd_d      = odd_q;
    lo_d       = lo_q;
    dq_d       = dq_q;
    dq_oen_d   = dq_oen_q;
    rwds_d     = rwds_q;
    rwds_oen_d = rwds_oen_q;
    we_c       = 1'b0;
    be_c       = 2'b00;
`ifdef HYPERRAM_RESPONDER_CR0_EN
    cr0_d      = cr0_q;
    reg_hi_d   = reg_hi_q;
    cr0_sel_d  = cr0_sel_q;
`endif

    case (state_q)
      IDLE: begin
        if (!hb.hb_csn_i) begin
          state_d    = CA;
          ca_cnt_d   = 3'd0;
          rwds_oen_d = 1'b0;
          rwds_d     = dbl_c;
        end
      end
      CA: begin
        if (cap_c) begin
          ca_d     = ca_full_c[39:0];
          ca_cnt_d = ca_cnt_q + 3'd1;
          if (ca_cnt_q == 3'd5) begin
            is_rd_d  = ca_full_c[CA_RD];
            is_reg_d = ca_full_c[CA_REG];
            lin_d    = ca_full_c[CA_LIN];
            addr_d   = ADDR_W'({ca_full_c[44:16], ca_full_c[2:0]});
            odd_d    = 1'b0;
`ifdef HYPERRAM_RESPONDER_CR0_EN
            cr0_sel_d = ({ca_full_c[24:16], ca_full_c[2:0]} == CR0_SEL);
`endif
            if (ca_full_c[CA_REG] && !ca_full_c[CA_RD]) begin
              state_d    = REG_WR;
              ca_cnt_d   = 3'd0;
              rwds_oen_d = 1'b1;
            end else begin
              state_d   = LAT;
              lat_cnt_d = lat_edges(lat_l_c, dbl_c);
              if (!ca_full_c[CA_RD]) rwds_oen_d = 1'b1;
            end
          end
        end
      end
      LAT: begin
        if (cap_c) begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
          if (lat_cnt_q == LAT_W'(1)) begin
            if (is_rd_q) begin
              // First read byte leaves on the last latency edge
              state_d  = READ;
              dq_d     = word_c[15:8];
              lo_d     = word_c[7:0];
              dq_oen_d = 1'b0;
              rwds_d   = 1'b0;
              odd_d    = 1'b1;
            end else begin
              state_d = WRITE;
              odd_d   = 1'b0;
            end
          end
        end
      end
      WRITE: begin
        if (cap_c) begin
          we_c  = !hb.hb_rwds_i;
          be_c  = odd_q ? 2'b01 : 2'b10;
          odd_d = !odd_q;
          if (odd_q) addr_d = addr_inc_c;
        end
      end
      READ: begin
        if (cap_c) begin
          rwds_d = !rwds_q;
          odd_d  = !odd_q;
          if (odd_q) begin
            dq_d   = lo_q;
            addr_d = addr_inc_c;
          end else begin
            dq_d = word_c[15:8];
            lo_d = word_c[7:0];
          end
        end
      end
      REG_WR: begin
`ifdef HYPERRAM_RESPONDER_CR0_EN
        // Two bytes, then edges are ignored until csn rises
        if (cap_c && ca_cnt_q < 3'd2) begin
          ca_cnt_d = ca_cnt_q + 3'd1;
          if (ca_cnt_q == 3'd0) reg_hi_d = hb.hb_dq_i;
          else if (cr0_sel_q) cr0_d = {reg_hi_q, hb.hb_dq_i};
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    // Deselect aborts any transaction
    if (hb.hb_csn_i) begin
      state_d    = IDLE;
      dq_oen_d   = 1'b1;
      rwds_oen_d = 1'b1;
      we_c       = 1'b0;
    end

    // HyperBus reset: same as wb_rst_i apart from RAM contents
    if (!hb.hb_rstn_i) begin
      state_d    = IDLE;
      ca_d       = '0;
      ca_cnt_d   = '0;
      lat_cnt_d  = '0;
      addr_d     = '0;
      is_rd_d    = 1'b0;
      is_reg_d   = 1'b0;
      lin_d      = 1'b0;
      odd_d      = 1'b0;
      lo_d       = '0;
      dq_d       = '0;
      dq_oen_d   = 1'b1;
      rwds_d     = 1'b0;
      rwds_oen_d = 1'b1;
      we_c       = 1'b0;
`ifdef HYPERRAM_RESPONDER_CR0_EN
      cr0_d      = CR0_RESET;
      reg_hi_d   = '0;
      cr0_sel_d  = 1'b0;
`endif
    end
  end

  // State and output registers
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      hb_clk_q   <= 1'b0;
      ca_q       <= '0;
      ca_cnt_q   <= '0;
      lat_cnt_q  <= '0;
      addr_q     <= '0;
      is_rd_q    <= 1'b0;
      is_reg_q   <= 1'b0;
      lin_q      <= 1'b0;
      odd_q      <= 1'b0;
      lo_q       <= '0;
      dq_q       <= '0;
      dq_oen_q   <= 1'b1;
      rwds_q     <= 1'b0;
      rwds_oen_q <= 1'b1;
      busy_q     <= 1'b0;
`ifdef HYPERRAM_RESPONDER_CR0_EN
      cr0_q      <= CR0_RESET;
      reg_hi_q   <= '0;
      cr0_sel_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      hb_clk_q   <= hb.hb_clk_i;
      ca_q       <= ca_d;
      ca_cnt_q   <= ca_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      addr_q     <= addr_d;
      is_rd_q    <= is_rd_d;
      is_reg_q   <= is_reg_d;
      lin_q      <= lin_d;
      odd_q      <= odd_d;
      lo_q       <= lo_d;
      dq_q       <= dq_d;
      dq_oen_q   <= dq_oen_d;
      rwds_q     <= rwds_d;
      rwds_oen_q <= rwds_oen_d;
      busy_q     <= (state_d != IDLE);
`ifdef HYPERRAM_RESPONDER_CR0_EN
      cr0_q      <= cr0_d;
      reg_hi_q   <= reg_hi_d;
      cr0_sel_q  <= cr0_sel_d;
`endif
    end
  end

  assign hb.hb_dq_o      = dq_q;
  assign hb.hb_dq_oen    = dq_oen_q;
  assign hb.hb_rwds_o    = rwds_q;
  assign hb.hb_rwds_oen  = rwds_oen_q;
  assign busy_o          = busy_q;

endmodule

// File: tb/tb_hyperram_responder.sv
// Directed bench for hyperram_responder: bus-level writes and read-backs,
// byte masking, abort, wrap modes, register space and reset behaviour.
module tb_hyperram_responder;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   checks = 0;
  int   errors = 0;
  int   exp_lat;
  logic exp_dbl;
  logic [15:0] exp_w [8];
  logic [15:0] reg_word;

  always #5 clk = ~clk;

  hyperram_responder_if hb();

  hyperram_responder #(.ADDR_W(10), .LATENCY_CLKS(6), .FIXED_LAT(1)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .hb       (hb),
    .busy_o   (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hb_edge(input logic [7:0] dq, input logic rwds);
    hb.hb_dq_i   = dq;
    hb.hb_rwds_i = rwds;
    hb.hb_clk_i  = ~hb.hb_clk_i;
    tick();
  endtask

  function automatic logic [47:0] mk_ca(input logic rd, input logic rg, input logic lin,
                                        input logic [31:0] waddr);
    logic [47:0] ca;
    ca        = '0;
    ca[47]    = rd;
    ca[46]    = rg;
    ca[45]    = lin;
    ca[44:16] = waddr[31:3];
    ca[2:0]   = waddr[2:0];
    return ca;
  endfunction

  task automatic start_ca(input logic [47:0] ca);
    hb.hb_csn_i = 1'b0;
    tick();
    chk("ca_rwds_oen", 32'(hb.hb_rwds_oen), 32'd0);
    chk("ca_rwds_lat", 32'(hb.hb_rwds_o), 32'(exp_dbl));
    for (int i = 0; i < 6; i++) hb_edge(ca[47-8*i -: 8], 1'b0);
  endtask

  task automatic end_tx();
    hb.hb_csn_i = 1'b1;
    tick();
    chk("end_dq_oen", 32'(hb.hb_dq_oen), 32'd1);
    chk("end_rwds_oen", 32'(hb.hb_rwds_oen), 32'd1);
    chk("end_busy", 32'(busy), 32'd0);
  endtask

  task automatic lat_phase(input int n);
    for (int i = 0; i < n; i++) hb_edge(8'h00, 1'b0);
  endtask

  task automatic wr_words(input logic [31:0] waddr, input logic lin, input int n);
    start_ca(mk_ca(1'b0, 1'b0, lin, waddr));
    lat_phase(exp_lat);
    for (int w = 0; w < n; w++) begin
      hb_edge(exp_w[w][15:8], 1'b0);
      hb_edge(exp_w[w][7:0], 1'b0);
    end
    end_tx();
  endtask

  // Last latency edge already presents the first byte
  task automatic rd_words(input string tag, input logic [31:0] waddr, input logic rg,
                          input logic lin, input int n);
    logic [15:0] w;
    logic [7:0]  b;
    start_ca(mk_ca(1'b1, rg, lin, waddr));
    lat_phase(exp_lat - 1);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    for (int k = 0; k < 2 * n; k++) begin
      hb_edge(8'h00, 1'b0);
      w = exp_w[k/2];
      b = (k % 2 == 0) ? w[15:8] : w[7:0];
      chk($sformatf("%s_dq%0d", tag, k), 32'(hb.hb_dq_o), 32'(b));
      chk($sformatf("%s_rwds%0d", tag, k), 32'(hb.hb_rwds_o), 32'(k % 2));
      if (k == 0) chk({tag, "_dq_oen"}, 32'(hb.hb_dq_oen), 32'd0);
    end
    end_tx();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst          = 1'b1;
    hb.hb_rstn_i = 1'b1;
    hb.hb_csn_i  = 1'b1;
    hb.hb_clk_i  = 1'b0;
    hb.hb_dq_i   = 8'h00;
    hb.hb_rwds_i = 1'b0;
    exp_lat      = 24;
    exp_dbl      = 1'b1;
    tick();
    tick();
    chk("rst_dq", 32'(hb.hb_dq_o), 32'h0);
    chk("rst_dq_oen", 32'(hb.hb_dq_oen), 32'd1);
    chk("rst_rwds", 32'(hb.hb_rwds_o), 32'd0);
    chk("rst_rwds_oen", 32'(hb.hb_rwds_oen), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    // Linear write then read-back, back-to-back with one idle cycle
    exp_w[0] = 16'h1234; exp_w[1] = 16'h5678;
    wr_words(32'h010, 1'b1, 2);
    rd_words("lin_rd", 32'h010, 1'b0, 1'b1, 2);

    // Reset in the middle of a read burst
    start_ca(mk_ca(1'b1, 1'b0, 1'b1, 32'h010));
    lat_phase(exp_lat + 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_dq_oen", 32'(hb.hb_dq_oen), 32'd1);
    chk("mid_rst_rwds_oen", 32'(hb.hb_rwds_oen), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    hb.hb_csn_i = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    rd_words("post_rst", 32'h010, 1'b0, 1'b1, 2);

    // Masked second byte, then a burst cut after one byte
    exp_w[0] = 16'hFFFF;
    wr_words(32'h020, 1'b1, 1);
    start_ca(mk_ca(1'b0, 1'b0, 1'b1, 32'h020));
    lat_phase(exp_lat);
    hb_edge(8'h12, 1'b0);
    hb_edge(8'h34, 1'b1);
    end_tx();
    exp_w[0] = 16'h12FF;
    rd_words("mask", 32'h020, 1'b0, 1'b1, 1);
    start_ca(mk_ca(1'b0, 1'b0, 1'b1, 32'h020));
    lat_phase(exp_lat);
    hb_edge(8'hAB, 1'b0);
    end_tx();
    exp_w[0] = 16'hABFF;
    rd_words("abort", 32'h020, 1'b0, 1'b1, 1);

    // Wrapped read across the 16-word group boundary
    exp_w[0] = 16'hA00E; exp_w[1] = 16'hA00F;
    wr_words(32'h00E, 1'b1, 2);
    exp_w[0] = 16'hA000; exp_w[1] = 16'hA001;
    wr_words(32'h000, 1'b1, 2);
    exp_w[0] = 16'hA00E; exp_w[1] = 16'hA00F; exp_w[2] = 16'hA000; exp_w[3] = 16'hA001;
    rd_words("wrap", 32'h00E, 1'b0, 1'b0, 4);

    // Linear burst wraps at the top of the array
    exp_w[0] = 16'hB3FF; exp_w[1] = 16'hB000;
    wr_words(32'h3FF, 1'b1, 2);
    rd_words("top", 32'h3FF, 1'b0, 1'b1, 2);

    // CR0 write: 0x8FE7 selects 3-clock 1x latency when the register exists
    start_ca(mk_ca(1'b0, 1'b1, 1'b0, 32'h800));
    hb_edge(8'h8F, 1'b0);
    hb_edge(8'hE7, 1'b0);
    end_tx();
`ifdef HYPERRAM_RESPONDER_CR0_EN
    exp_dbl  = 1'b0;
    exp_lat  = 6;
    reg_word = 16'h8FE7;
`else
    reg_word = 16'h0000;
`endif
    exp_w[0] = 16'h1234; exp_w[1] = 16'h5678;
    rd_words("cfg_rd", 32'h010, 1'b0, 1'b1, 2);
    exp_w[0] = reg_word;
    rd_words("reg_rd", 32'h800, 1'b1, 1'b0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
